// File: rtl/zelda_pkg.sv
// Shared constants and types for the sprite/tile ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package zelda_pkg;

    // Requester slots on the pixel pipeline
    localparam int REQ_BG    = 0;
    localparam int REQ_LINK  = 1;
    localparam int REQ_ENEMY = 2;

    // Default ROM geometry
    localparam int ROM_ADDR_W = 10;
    localparam int PAL_IDX_W  = 4;

    typedef logic [ROM_ADDR_W-1:0] rom_addr_t;
    typedef logic [PAL_IDX_W-1:0]  pal_idx_t;

    // Index increment wrapping from n-1 back to 0 (n need not be a power of two)
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/zelda_rr_pick.sv
// Rotating priority encoder: first asserted req at or after rr_ptr, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module zelda_rr_pick
    import zelda_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int cand;

    // Walk N slots starting at rr_ptr; the first requester found wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = int'(rr_ptr);
        if (cand >= N) begin
            cand = 0;
        end
        for (int off = 0; off < N; off++) begin
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = PTR_W'(cand);
                gnt_any   = 1'b1;
            end
            cand = wrap_inc(cand, N);
        end
    end

endmodule

// File: rtl/zelda_rom_arbiter.sv
// Shares one single-port sprite/tile ROM among pixel requesters; optional background priority via ZELDA_ROM_ARB_BG_PRIORITY_EN.
// Latency: gnt/rom_address same cycle as req; rvalid/rdata ROM_LAT+1 cycles after grant.
// Backpressure: losers simply stay ungranted and hold req/addr; returning data cannot be stalled.
module zelda_rom_arbiter
    import zelda_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                          vga_clk,
    input  logic                          Reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
    output logic [N_REQ-1:0]              gnt,
    output logic [ADDR_W-1:0]             rom_address,
    output logic                          rom_en,
    input  logic [DATA_W-1:0]             rom_q,
    output logic [N_REQ-1:0]              rvalid,
    output logic [DATA_W-1:0]             rdata
);

    localparam int PTR_W = $clog2(N_REQ);

`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
    // Pointer never rests on the background slot in this mode
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  gnt_raw;

    logic [N_REQ-1:0]  tag_q [ROM_LAT];
    logic [N_REQ-1:0]  tag_d [ROM_LAT];
    logic [N_REQ-1:0]  tag_out;

    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Requests seen by the rotating encoder (background removed when it has its own priority)
    always_comb begin
        pick_req = req;
`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
        pick_req[REQ_BG] = 1'b0;
`endif
    end

    zelda_rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (pick_req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Final grant selection and next round-robin pointer
    always_comb begin
        gnt_raw  = pick_gnt;
        rr_ptr_d = rr_ptr_q;
`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
        if (req[REQ_BG]) begin
            gnt_raw         = '0;
            gnt_raw[REQ_BG] = 1'b1;
        end else if (pick_any) begin
            rr_ptr_d = PTR_W'(wrap_inc(int'(pick_idx), N_REQ));
            if (rr_ptr_d == '0) begin
                rr_ptr_d = PTR_W'(1);
            end
        end
`else
        if (pick_any) begin
            rr_ptr_d = PTR_W'(wrap_inc(int'(pick_idx), N_REQ));
        end
`endif
    end

    // Outputs toward the ROM; forced quiet while Reset is asserted
    always_comb begin
        gnt         = Reset ? '0 : gnt_raw;
        rom_en      = |gnt;
        rom_address = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                rom_address = rom_address | addr[i];
            end
        end
    end

    // Tag shift register follows each grant through the ROM latency
    always_comb begin
        tag_d[0] = gnt_raw;
        for (int s = 1; s < ROM_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        tag_out = tag_q[ROM_LAT-1];
    end

    // Return stage: pulse rvalid for one cycle, hold rdata between returns
    always_comb begin
        rvalid_d = tag_out;
        rdata_d  = (|tag_out) ? rom_q : rdata_q;
    end

    // State registers; reset discards all in-flight tags
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr_q <= PTR_RST;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_q[s] <= '0;
            end
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_zelda_rom_arbiter.sv
// Self-checking bench for zelda_rom_arbiter with a behavioural one-cycle ROM.
// Latency: expects returns two cycles after each grant (ROM_LAT=1).
// Backpressure: none modelled; held requests are re-driven each cycle.
module tb_zelda_rom_arbiter;
    import zelda_pkg::*;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 4;

    logic                   vga_clk = 1'b0;
    logic                   Reset   = 1'b1;
    logic [N-1:0]           req     = '0;
    logic [N-1:0][AW-1:0]   addr    = '0;
    logic [N-1:0]           gnt;
    logic [AW-1:0]          rom_address;
    logic                   rom_en;
    logic [DW-1:0]          rom_q   = '0;
    logic [N-1:0]           rvalid;
    logic [DW-1:0]          rdata;

    zelda_rom_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (1)
    ) dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_en      (rom_en),
        .rom_q       (rom_q),
        .rvalid      (rvalid),
        .rdata       (rdata)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM contents as a fixed function of the address
    function automatic pal_idx_t rom_fn(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
    endfunction

    always @(posedge vga_clk) begin
        if (rom_en) rom_q <= rom_fn(rom_address);
    end

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [N-1:0] oh;
        pal_idx_t     data;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           m_ptr  = 0;
    pal_idx_t     exp_rdata = '0;
    logic [N-1:0][AW-1:0] a_def;

    // Reference arbitration
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int ptr);
        logic [N-1:0] g;
        g = '0;
`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
        if (r[0]) begin
            g[0] = 1'b1;
            return g;
        end
        for (int off = 0; off < N; off++) begin
            int k;
            k = (ptr + off) % N;
            if (k != 0 && r[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
`else
        for (int off = 0; off < N; off++) begin
            int k;
            k = (ptr + off) % N;
            if (r[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
`endif
        return g;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic model_commit(input logic [N-1:0] g);
        int k;
        if (g == '0) return;
        k = oh_idx(g);
`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
        if (k != 0) begin
            m_ptr = (k + 1) % N;
            if (m_ptr == 0) m_ptr = 1;
        end
`else
        m_ptr = (k + 1) % N;
`endif
    endtask

    // Drive one cycle of stimulus just after the edge; expected grant returned, return queued
    task automatic drive(input logic [N-1:0] r, input logic [N-1:0][AW-1:0] a,
                         output logic [N-1:0] exp_g);
        exp_t e;
        @(posedge vga_clk);
        #1;
        req  = r;
        addr = a;
        #2;
        exp_g = Reset ? '0 : model_pick(r, m_ptr);
        if (exp_g != '0) begin
            e.due  = cyc + 2;
            e.oh   = exp_g;
            e.data = rom_fn(a[oh_idx(exp_g)]);
            sb.push_back(e);
            model_commit(exp_g);
        end
    endtask

    // Return-path scoreboard, sampled mid-cycle
    initial begin
        forever begin
            exp_t e;
            @(posedge vga_clk);
            #2;
            checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_rdata = e.data;
                if (rvalid !== e.oh || rdata !== e.data) begin
                    errors++;
                    $display("FAIL sb_return cyc=%0d rvalid=%b rdata=%h required rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, e.oh, e.data);
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                errors++;
                $display("FAIL sb_missed cyc=%0d due=%0d rvalid=%b required rvalid=%b", cyc, e.due, rvalid, e.oh);
            end else if (rvalid !== '0 || rdata !== exp_rdata) begin
                errors++;
                $display("FAIL sb_idle cyc=%0d rvalid=%b rdata=%h required rvalid=000 rdata=%h",
                         cyc, rvalid, rdata, exp_rdata);
            end
        end
    end

    task automatic reset_pulse();
        @(posedge vga_clk);
        #1;
        Reset = 1'b1;
        req   = '0;
        sb.delete();
        exp_rdata = '0;
        m_ptr = 0;
        @(posedge vga_clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] eg;
        repeat (2) @(posedge vga_clk);
        drive(3'b111, a_def, eg);
        checks++;
        if (gnt !== 3'b000 || rom_en !== 1'b0 || rom_address !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b rom_en=%b rom_address=%h required 000/0/000", gnt, rom_en, rom_address);
        end
        checks++;
        if (rvalid !== 3'b000 || rdata !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs rvalid=%b rdata=%h required 000/0", rvalid, rdata);
        end
        @(posedge vga_clk);
        #1;
        Reset = 1'b0;
        req   = '0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        logic [N-1:0] eg;
        logic [N-1:0][AW-1:0] a;
        a = a_def;
        a[1] = 10'h155;
        drive(3'b010, a, eg);
        checks++;
        if (gnt !== 3'b010 || gnt !== eg || rom_address !== 10'h155 || rom_en !== 1'b1) begin
            errors++;
            $display("FAIL single_grant gnt=%b rom_address=%h rom_en=%b required 010/155/1", gnt, rom_address, rom_en);
        end
        drive(3'b000, a, eg);
        checks++;
        if (rvalid !== 3'b000) begin
            errors++;
            $display("FAIL single_early rvalid=%b required 000", rvalid);
        end
        drive(3'b000, a, eg);
        checks++;
        if (rvalid !== 3'b010 || rdata !== rom_fn(10'h155)) begin
            errors++;
            $display("FAIL single_return rvalid=%b rdata=%h required 010/%h", rvalid, rdata, rom_fn(10'h155));
        end
    endtask

    task automatic test_all_rr();
        logic [N-1:0] eg;
        logic [N-1:0] seq;
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            drive(3'b111, a_def, eg);
            seq = 3'b001 << (i % 3);
            checks++;
            if (gnt !== seq || gnt !== eg) begin
                errors++;
                $display("FAIL rr_seq i=%0d gnt=%b required %b", i, gnt, seq);
            end
            if (i >= 2) begin
                seq = 3'b001 << ((i - 2) % 3);
                checks++;
                if (rvalid !== seq) begin
                    errors++;
                    $display("FAIL rr_rvalid i=%0d rvalid=%b required %b", i, rvalid, seq);
                end
            end
        end
        drive(3'b000, a_def, eg);
        drive(3'b000, a_def, eg);
    endtask

    task automatic test_ptr_hold();
        logic [N-1:0] eg;
        drive(3'b010, a_def, eg);
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL hold_first gnt=%b required 010", gnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, a_def, eg);
            checks++;
            if (gnt !== 3'b000 || rom_en !== 1'b0 || rom_address !== '0) begin
                errors++;
                $display("FAIL hold_idle i=%0d gnt=%b rom_en=%b rom_address=%h required 000/0/000",
                         i, gnt, rom_en, rom_address);
            end
        end
        drive(3'b111, a_def, eg);
        checks++;
        if (gnt !== 3'b100 || gnt !== eg) begin
            errors++;
            $display("FAIL hold_resume gnt=%b required 100", gnt);
        end
        drive(3'b000, a_def, eg);
        drive(3'b000, a_def, eg);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] eg;
        drive(3'b100, a_def, eg);
        checks++;
        if (gnt !== 3'b100) begin
            errors++;
            $display("FAIL rmid_grant gnt=%b required 100", gnt);
        end
        @(posedge vga_clk);
        #1;
        Reset = 1'b1;
        req   = 3'b111;
        sb.delete();
        exp_rdata = '0;
        m_ptr = 0;
        #2;
        checks++;
        if (gnt !== 3'b000 || rom_en !== 1'b0 || rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rmid_during gnt=%b rom_en=%b rvalid=%b required 000/0/000", gnt, rom_en, rvalid);
        end
        @(posedge vga_clk);
        #1;
        Reset = 1'b0;
        req   = '0;
        #2;
        checks++;
        if (rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rmid_release rvalid=%b required 000", rvalid);
        end
        for (int i = 0; i < 2; i++) begin
            drive(3'b000, a_def, eg);
            checks++;
            if (rvalid !== 3'b000) begin
                errors++;
                $display("FAIL rmid_after i=%0d rvalid=%b required 000", i, rvalid);
            end
        end
        drive(3'b111, a_def, eg);
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL rmid_restart gnt=%b required 001", gnt);
        end
        drive(3'b000, a_def, eg);
        drive(3'b000, a_def, eg);
    endtask

    task automatic test_withdraw();
        logic [N-1:0] eg;
        drive(3'b100, a_def, eg);
        drive(3'b000, a_def, eg);
        drive(3'b000, a_def, eg);
        drive(3'b101, a_def, eg);
        checks++;
        if (gnt !== 3'b001 || gnt !== eg) begin
            errors++;
            $display("FAIL wd_grant gnt=%b required 001", gnt);
        end
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, a_def, eg);
            checks++;
            if (gnt[2] !== 1'b0 || rvalid[2] !== 1'b0) begin
                errors++;
                $display("FAIL wd_after i=%0d gnt=%b rvalid=%b required bit2 clear", i, gnt, rvalid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] eg;
        logic [N-1:0][AW-1:0] a;
        a = a_def;
        for (int i = 0; i < 4; i++) begin
            a[0] = 10'h010 + AW'(i * 10'h111);
            drive(3'b001, a, eg);
            checks++;
            if (gnt !== 3'b001 || rom_address !== a[0]) begin
                errors++;
                $display("FAIL b2b_grant i=%0d gnt=%b rom_address=%h required 001/%h", i, gnt, rom_address, a[0]);
            end
            if (i >= 2) begin
                checks++;
                if (rvalid !== 3'b001) begin
                    errors++;
                    $display("FAIL b2b_overlap i=%0d rvalid=%b required 001", i, rvalid);
                end
            end
        end
        drive(3'b000, a, eg);
        drive(3'b000, a, eg);
    endtask

`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
    task automatic test_bg_priority();
        logic [N-1:0] eg;
        logic [N-1:0] seq;
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, a_def, eg);
            checks++;
            if (gnt !== 3'b001) begin
                errors++;
                $display("FAIL bg_win i=%0d gnt=%b required 001", i, gnt);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(3'b110, a_def, eg);
            seq = (i % 2 == 0) ? 3'b010 : 3'b100;
            checks++;
            if (gnt !== seq) begin
                errors++;
                $display("FAIL bg_rr i=%0d gnt=%b required %b", i, gnt, seq);
            end
        end
        drive(3'b000, a_def, eg);
        drive(3'b000, a_def, eg);
    endtask
`endif

    initial begin
        a_def[0] = 10'h0A3;
        a_def[1] = 10'h155;
        a_def[2] = 10'h2E7;
        test_reset();
        test_single();
`ifdef ZELDA_ROM_ARB_BG_PRIORITY_EN
        test_bg_priority();
`else
        test_all_rr();
        test_ptr_hold();
        test_reset_mid();
        test_withdraw();
`endif
        test_back_to_back();
        repeat (3) @(posedge vga_clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zelda_rom_arbiter.md
# zelda_rom_arbiter

Shares one synchronous sprite/tile ROM, with a single read port, between several pixel-pipeline requesters: the background tile fetcher, the Link sprite and the enemy sprites. Each cycle it grants one requester using round-robin or background-priority arbitration and drives the ROM address. It tracks each in-flight read through the ROM latency and returns the palette index to the requester that issued it. It sits between the per-layer address generators and the ROM, ahead of the palette lookup.

## Interface
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM word (palette index) width
- ROM_LAT, 1, ROM read latency in cycles (address sampled to rom_q valid), 1..3

Ports:
- vga_clk  in  1  sole clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester read request, level
- addr  in  N_REQ x ADDR_W  per-requester address, packed [N_REQ-1:0][ADDR_W-1:0]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as req
- rom_address  out  ADDR_W  address to ROM, combinational mux of granted addr
- rom_en  out  1  high in any cycle with a grant
- rom_q  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en
- rvalid  out  N_REQ  one-hot, registered; data for that requester on rdata
- rdata  out  DATA_W  registered read data

## Operation
- Handshake: a transfer occurs in a cycle where req[i] and gnt[i] are both high.
  - addr[i] must be held stable while req[i] is high and ungranted.
  - req[i] may be withdrawn before grant with no side effect.
  - A requester holding req high after grant gets back-to-back reads when it is re-selected.
- Arbitration (default): round-robin.
  - Pointer rr_ptr (clog2(N_REQ) bits) marks the highest-priority index.
  - Search order is rr_ptr, rr_ptr+1, … wrapping modulo N_REQ (not power-of-two: wrap from N_REQ-1 to 0).
  - On a grant to index k, rr_ptr <= (k+1) mod N_REQ.
  - With no grant, rr_ptr is held.
- At most one gnt bit is high per cycle. gnt is 0 when req is 0 or Reset is high.
- rom_address = addr[k] for granted k; 0 when no grant. rom_en = |gnt.
- Tag pipeline: ROM_LAT-stage shift register of the one-hot gnt.
  - At the output, rvalid <= tag_out and rdata <= rom_q when tag_out is nonzero.
  - Otherwise rdata holds its value and rvalid <= 0.
- Fairness: with all N_REQ requesters asserting continuously, each is granted exactly once every N_REQ cycles.

## Timing
- Throughput: one read per cycle, with no bubbles between grants.
- Latency: grant in cycle T means rvalid[k]/rdata valid in cycle T+ROM_LAT+1, a one-cycle pulse per grant.
- Reset values: rr_ptr=0, tag pipeline all 0, rvalid=0, rdata=0. gnt, rom_en and rom_address are 0 while Reset is high.
- Reset mid-operation: in-flight tags are discarded. No rvalid is produced for grants issued before Reset, including those whose data arrives after release.
- First cycle after Reset release: arbitration resumes from index 0.
- Simultaneous events: a new grant and a returning rvalid in the same cycle are independent. A requester may receive rvalid and gnt in the same cycle.

## Configuration
- ZELDA_ROM_ARB_BG_PRIORITY_EN defined:
  - Requester 0 (background) wins whenever req[0] is high.
  - Indices 1..N_REQ-1 round-robin among themselves when req[0] is low.
  - rr_ptr ranges over 1..N_REQ-1 only, and is unchanged by grants to 0.
  - Starvation of 1..N_REQ-1 is possible by design; the background fetcher must leave idle cycles.
- Undefined: pure round-robin over all N_REQ as above.

## Structure
- Package zelda_pkg holds:
  - Requester index constants REQ_BG=0, REQ_LINK=1, REQ_ENEMY=2.
  - typedef rom_addr_t (logic [ADDR_W-1:0] at default widths).
  - typedef pal_idx_t (logic [DATA_W-1:0]).
- One sub-module, zelda_rr_pick: combinational rotating priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot gnt and granted index.
  - Reused by the BG-priority variant over the reduced vector.
- Tag pipeline and output registers live in zelda_rom_arbiter.

## Test plan
- Single requester: req=3'b010, addr[1]=10'h155 held 1 cycle -> gnt=3'b010 and rom_address=10'h155 same cycle; rvalid=3'b010 with rdata = ROM[0x155] exactly 2 cycles later (ROM_LAT=1).
- All requesting continuously from reset -> grant sequence 001, 010, 100, 001 …; rvalid follows the same sequence delayed 2 cycles, with no idle cycles.
- Pointer hold: grant to 1, then 3 idle cycles, then req=3'b111 -> grant to 2 first.
- Reset pulse one cycle after a grant to requester 2 -> no rvalid in the following 4 cycles; next req=3'b111 grants index 0.
- Withdrawal: req[2] high 1 cycle while requester 0 is granted, then low -> requester 2 never granted; no rvalid[2].
- With ZELDA_ROM_ARB_BG_PRIORITY_EN and req=3'b111 for 4 cycles -> gnt=001 every cycle. Then req=3'b110 -> grants alternate 010, 100.
